// File: rtl/bin2sseg_fmt.sv
// rtl/bin2sseg_fmt.sv - iterative binary to 4-digit seven-segment formatter feeding disp_mux
//
// Purpose: on a start pulse, converts bin to four BCD digits by shift-add-3
// (one bit per clock), then encodes them to active-low segment patterns
// (bit7 = dp, bit6..0 = a..g) with leading-zero blanking, per-digit decimal
// points and an all-dash overflow display for values above 9999.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high reset
//   start    - conversion request, honoured only in IDLE
//   bin      - unsigned value to display, captured with start
//   blank_lz - blank leading zero digits, captured with start
//   dp_en    - decimal point enables, bit3 -> in3 .. bit0 -> in0, captured with start
//   busy     - high from the cycle after start is accepted until done
//   done     - one-cycle pulse when in3..in0 update
//   in3..in0 - held segment patterns, in3 most significant
module bin2sseg_fmt #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  input  logic             blank_lz,
  input  logic [3:0]       dp_en,
  output logic             busy,
  output logic             done,
  output logic [7:0]       in3,
  output logic [7:0]       in2,
  output logic [7:0]       in1,
  output logic [7:0]       in0
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, ENC} state_t;

  state_t           state, state_nx;
  logic [BIN_W-1:0] shift;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [CW-1:0]    cnt;
  logic             lz;
  logic             ovf;
  logic [3:0]       dp;
  logic [7:0]       enc [4];

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'h81;
      4'd1:    seg_code = 8'hCF;
      4'd2:    seg_code = 8'h92;
      4'd3:    seg_code = 8'h86;
      4'd4:    seg_code = 8'hCC;
      4'd5:    seg_code = 8'hA4;
      4'd6:    seg_code = 8'hA0;
      4'd7:    seg_code = 8'h8F;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h84;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CONV;
      CONV:    if (cnt == LAST) state_nx = ENC;
      ENC:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Add-3 correction applied before every shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Digit encoding. A digit is blanked only if it and every digit above it
  // are zero; in0 is never blanked so zero still shows a single "0".
  always_comb begin
    logic [3:0] blank;
    blank[3] = lz && (bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd[7:4] == 4'd0);
    blank[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ovf)           enc[i] = 8'hFE;
      else if (blank[i]) enc[i] = 8'hFF;
      else               enc[i] = seg_code(bcd[4*i +: 4]);
      if (dp[i]) enc[i][7] = 1'b0;
    end
  end

  // Datapath and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      in3   <= 8'hFF;
      in2   <= 8'hFF;
      in1   <= 8'hFF;
      in0   <= 8'hFF;
      shift <= '0;
      bcd   <= '0;
      cnt   <= '0;
      lz    <= 1'b0;
      ovf   <= 1'b0;
      dp    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift <= bin;
            bcd   <= '0;
            cnt   <= '0;
            lz    <= blank_lz;
            dp    <= dp_en;
            ovf   <= ({{(32-BIN_W){1'b0}}, bin} > 32'd9999);
            busy  <= 1'b1;
          end
        end
        CONV: begin
          bcd   <= {bcd_adj[14:0], shift[BIN_W-1]};
          shift <= {shift[BIN_W-2:0], 1'b0};
          cnt   <= cnt + CW'(1);
        end
        ENC: begin
          in3  <= enc[3];
          in2  <= enc[2];
          in1  <= enc[1];
          in0  <= enc[0];
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2sseg_fmt.sv
// tb/tb_bin2sseg_fmt.sv - directed self-checking bench for bin2sseg_fmt
module tb_bin2sseg_fmt;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic        blank_lz;
  logic [3:0]  dp_en;
  logic        busy;
  logic        done;
  logic [7:0]  in3, in2, in1, in0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin2sseg_fmt #(.BIN_W(14)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .blank_lz (blank_lz),
    .dp_en    (dp_en),
    .busy     (busy),
    .done     (done),
    .in3      (in3),
    .in2      (in2),
    .in1      (in1),
    .in0      (in0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {in3, in2, in1, in0};
  endfunction

  // Drive start for one edge (E0) and return with E0 just passed (+1).
  task automatic kick(input int b, input logic blz, input logic [3:0] dpe);
    @(negedge clk);
    start = 1'b1; bin = 14'(b); blank_lz = blz; dp_en = dpe;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Optional injection: kind 1 = start with bin=7777 after edge inj_at.
  task automatic run_conv(input string tag, input int b, input logic blz,
                          input logic [3:0] dpe, input logic [31:0] exp,
                          input int kind, input int inj_at);
    int lat;
    int extra;
    kick(b, blz, dpe);
    check({tag, ".busy0"}, 32'(busy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (kind == 1 && n == inj_at) begin
        start = 1'b1; bin = 14'd7777; blank_lz = 1'b1; dp_en = 4'hF;
      end else begin
        start = 1'b0;
      end
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
    check({tag, ".lat"}, 32'(lat), 32'd15);
    check({tag, ".segs"}, outs(), exp);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    if (kind == 1) begin
      extra = 0;
      for (int n = 0; n < 20; n++) begin
        @(posedge clk); #1;
        if (done || busy) extra++;
      end
      check({tag, ".no_queue"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int seen;
    int first, second;
    reset = 1'b1; start = 1'b0; bin = '0; blank_lz = 1'b0; dp_en = '0;
    repeat (3) @(posedge clk);
    // start asserted together with reset must be ignored
    @(negedge clk); start = 1'b1; bin = 14'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.segs", outs(), 32'hFFFFFFFF);
    repeat (3) @(posedge clk); #1;
    check("rst.start_ignored", 32'(busy), 32'd0);

    run_conv("c1234",  1234,  1'b0, 4'b0000, 32'hCF9286CC, 0, 0);
    run_conv("c42lz",  42,    1'b1, 4'b0000, 32'hFFFFCC92, 0, 0);
    run_conv("c0lz",   0,     1'b1, 4'b0000, 32'hFFFFFF81, 0, 0);
    run_conv("c0",     0,     1'b0, 4'b0000, 32'h81818181, 0, 0);
    run_conv("c1005",  1005,  1'b1, 4'b0000, 32'hCF8181A4, 0, 0);
    run_conv("c9999",  9999,  1'b0, 4'b0000, 32'h84848484, 0, 0);
    run_conv("c10000", 10000, 1'b1, 4'b0000, 32'hFEFEFEFE, 0, 0);
    run_conv("c16383", 16383, 1'b0, 4'b0001, 32'hFEFEFE7E, 0, 0);
    run_conv("dp1234", 1234,  1'b0, 4'b0100, 32'hCF1286CC, 0, 0);
    run_conv("dp5",    5,     1'b1, 4'b1000, 32'h7FFFFFA4, 0, 0);
    run_conv("busy_start", 1234, 1'b0, 4'b0000, 32'hCF9286CC, 1, 5);
    run_conv("after_busy", 2468, 1'b0, 4'b0000, 32'h92CCA080, 0, 0);

    // Reset mid-conversion: outputs blank, no done for the aborted run
    kick(1234, 1'b0, 4'b0000);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst.segs", outs(), 32'hFFFFFFFF);
    check("midrst.busy", 32'(busy), 32'd0);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst.no_done", 32'(seen), 32'd0);
    run_conv("c56", 56, 1'b0, 4'b0000, 32'h8181A4A0, 0, 0);

    // start held high: back-to-back with one IDLE cycle between
    @(negedge clk);
    start = 1'b1; bin = 14'd9999; blank_lz = 1'b0; dp_en = 4'b0000;
    @(posedge clk); #1;
    first = 0; second = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first == 0) first = n;
        else if (second == 0) second = n;
      end
    end
    start = 1'b0;
    check("b2b.first", 32'(first), 32'd15);
    check("b2b.second", 32'(second), 32'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
